uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares the single UART transmit FIFO between several byte-stream message sources (e.g. command echo, status reporter, error reporter). It sits between the requesters and the TX FIFO write port. It grants one requester at a time for a whole message, delimited by a `last` flag. It releases a stalled requester after a programmable idle timeout.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters. Supported range is 2..4.
- `TIMEOUT`, 200: number of consecutive idle grant cycles before forced release. A value of 0 disables the timeout.
- `TIMEOUT_WIDTH`, 8: width of the timeout counter. Must satisfy `TIMEOUT < 2**TIMEOUT_WIDTH`.

Ports:
- `clock`  in  1  single clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `req_data`  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i has a byte on its lane.
- `req_last`  in  NUM_REQ  the byte on lane i is the final byte of its message.
- `req_ready`  out  NUM_REQ  the byte on lane i is accepted this cycle when valid.
- `fifo_full`  in  1  full flag of the TX FIFO.
- `fifo_data`  out  8  write data to the TX FIFO.
- `fifo_write`  out  1  write strobe to the TX FIFO.
- `grant`  out  NUM_REQ  one-hot index of the current owner; all zero when idle.
- `busy`  out  1  high while a grant is held.
- `timeout_err`  out  1  one-cycle pulse when a grant is forcibly released.

## Operation
State machine with two states, IDLE and GRANT.

IDLE:
- `grant` = 0.
- If any `req_valid` bit is high, select the winner by round-robin. The search starts at index (`last_idx`+1) mod NUM_REQ and the first valid index wins.
- Register `grant` = one-hot(winner) and go to GRANT.
- If no `req_valid` bit is high, stay in IDLE.

GRANT, with owner index g:
- `req_ready[g]` = ~`fifo_full`. All other `req_ready` bits are 0.
- A transfer occurs when `req_valid[g]` & `req_ready[g]` are both high.
- `fifo_write` = transfer. It is combinational and never asserted while `fifo_full` is high.
- `fifo_data` = lane g of `req_data`. It is a don't-care when `fifo_write` is 0; drive lane g or 0.
- Transfer with `req_last[g]` high: set `last_idx` = g, clear `grant`, go to IDLE.
- Idle-cycle counting:
  - A cycle with `req_valid[g]` low increments the idle counter.
  - A cycle with `fifo_full` high holds the counter; a full-FIFO stall is never a timeout.
  - Any transfer clears the counter.
- When the counter reaches TIMEOUT (and TIMEOUT≠0):
  - Pulse `timeout_err` for one cycle.
  - Set `last_idx` = g, clear `grant`, go to IDLE.
  - The truncated message is not completed; later bytes from g start a new arbitration.
- The grant is held while `req_valid` is low mid-message. Other requesters wait and are not preempted.
- `req_valid` and `req_last` on non-owner lanes are ignored.

Other rules:
- `busy` = (state == GRANT).
- `req_ready` is 0 for every lane in IDLE.

## Timing
- Reset values:
  - state = IDLE, `grant` = 0, `busy` = 0, `timeout_err` = 0.
  - Idle counter = 0.
  - `last_idx` = NUM_REQ−1, so requester 0 wins first after reset.
  - `req_ready` = 0, `fifo_write` = 0.
- Reset mid-message: `grant` clears at the reset edge, and no further write occurs in the cycle after the reset edge.
- Grant latency: `req_valid` rises in IDLE at cycle t, `grant` is valid at t+1, and the first write can occur at t+1.
- Inside a message, one byte is transferred per cycle while the FIFO is not full.
- Between messages there is exactly one IDLE cycle: `last` is transferred at t, the block is in IDLE at t+1, and the next grant is at t+2.
- A single requester sending back-to-back messages re-wins at t+2 if no other lane is valid.
- Simultaneous requests: strict round-robin. With all lanes valid continuously, grants rotate 0,1,…,NUM_REQ−1,0.
- Timeout: with `req_valid[g]` low for TIMEOUT consecutive counted cycles, `timeout_err` is high in the cycle after the TIMEOUT-th idle cycle, together with `grant` = 0.
- A transfer of a `last` byte in the same cycle as the counter reaching TIMEOUT is a normal end. `timeout_err` stays 0.

## Test plan
- Reset, then req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43 → `grant` = 01 one cycle after valid; `fifo_write` on 3 consecutive cycles with those bytes; `grant` = 00 afterwards; `busy` low.
- Both lanes valid continuously, each sending 2-byte messages (req0: 0x10,0x11; req1: 0x20,0x21) → FIFO receives 0x10,0x11,0x20,0x21,0x10,… with exactly one IDLE cycle between messages.
- `fifo_full` held high for 5 cycles mid-message on req1 → `req_ready` = 0, no `fifo_write`, no `timeout_err`, grant held; the message resumes intact with no byte lost or duplicated.
- TIMEOUT=8: req0 sends 1 byte without last, then drops `req_valid` while req1 waits → `timeout_err` pulses once after 8 idle cycles, then req1 is granted on the following IDLE→GRANT transition.
- Reset asserted on the second byte of a 4-byte message → `grant`, `busy` and `fifo_write` are 0 after the reset edge, and the next arbitration selects req0 first.
- NUM_REQ=4, lanes 1 and 3 valid after a message from lane 1 completes → lane 3 wins (search order 2,3,0,1).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin arbiter sharing the UART TX FIFO write port
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int TIMEOUT       = 200,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic [7:0]           fifo_data,
  output logic                 fifo_write,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT_WIDTH'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         owner;
  logic [IDX_W-1:0]         last_idx;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_found;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_nxt;
  logic                     owner_valid;
  logic                     owner_last;
  logic                     xfer;

  // Round-robin search starting just after the previous owner; first valid lane wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = last_idx;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Steer the owner's lane onto the FIFO side; non-owner lanes are never looked at.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    fifo_data   = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        fifo_data   = req_data[8*i +: 8];
      end
    end
  end

  assign busy         = (state == GRANT);
  assign xfer         = busy & owner_valid & ~fifo_full;
  assign fifo_write   = xfer;
  assign req_ready    = {NUM_REQ{busy & ~fifo_full}} & grant;
  assign idle_cnt_nxt = idle_cnt + TIMEOUT_WIDTH'(1);

  // Grant FSM: hold the owner for a whole message, release on last byte or idle timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      last_idx    <= LAST_RESET;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            owner    <= win_idx;
            grant    <= NUM_REQ'(1) << win_idx;
            idle_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (owner_last) begin
              state    <= IDLE;
              grant    <= '0;
              last_idx <= owner;
            end
          end else if (!fifo_full && !owner_valid) begin
            // A full FIFO freezes the count; only a silent owner ages the grant.
            if ((TIMEOUT != 0) && (idle_cnt_nxt == TIMEOUT_CNT)) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
              grant       <= '0;
              last_idx    <= owner;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt_nxt;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic [7:0]  fifo_data;
  logic        fifo_write;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_to  = 0;

  logic [8:0] lane_q [4][$];
  logic [7:0] got [$];

  logic [3:0] gtab [13] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0};
  logic       wtab [13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] t2_exp [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h10, 8'h11, 8'h20, 8'h21};

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .TIMEOUT       (8),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_data   (fifo_data),
    .fifo_write  (fifo_write),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO-side monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (fifo_write) got.push_back(fifo_data);
    if (timeout_err) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (lane_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = lane_q[i][0][8];
        req_data[8*i +: 8] = lane_q[i][0][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) lane_q[i].delete();
  endtask

  // One clock: note handshakes mid-cycle, then advance sources just after the edge
  task automatic cycle();
    logic [3:0] x;
    @(negedge clock);
    x = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) if (x[i]) void'(lane_q[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fifo_full = 1'b0;
    clear_lanes();
    drive();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    got.delete();
  endtask

  task automatic check_got(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    check({tag, "_n"}, got.size(), 2);
    if (got.size() == 2) begin
      check({tag, "_b0"}, got[0], e0);
      check({tag, "_b1"}, got[1], e1);
    end
  endtask

  initial begin
    int to_base;
    reset     = 1'b1;
    fifo_full = 1'b0;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;

    // Reset state
    do_reset();
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_to", timeout_err, 0);
    check("rst_ready", req_ready, 0);
    check("rst_write", fifo_write, 0);

    // Single 3-byte message from req0
    lane_q[0].push_back({1'b0, 8'h41});
    lane_q[0].push_back({1'b0, 8'h42});
    lane_q[0].push_back({1'b1, 8'h43});
    drive(); #1;
    check("t1_idle_grant", grant, 0);
    cycle(); #1;
    check("t1_grant", grant, 4'b0001);
    check("t1_ready", req_ready, 4'b0001);
    check("t1_w0", fifo_write, 1);
    check("t1_d0", fifo_data, 8'h41);
    cycle(); #1;
    check("t1_w1", fifo_write, 1);
    check("t1_d1", fifo_data, 8'h42);
    cycle(); #1;
    check("t1_w2", fifo_write, 1);
    check("t1_d2", fifo_data, 8'h43);
    cycle(); #1;
    check("t1_end_grant", grant, 0);
    check("t1_end_busy", busy, 0);
    check("t1_n", got.size(), 3);
    if (got.size() == 3) check("t1_seq", {got[0], got[1], got[2]}, 24'h414243);

    // Two lanes continuously valid: strict alternation with one IDLE cycle between messages
    do_reset();
    for (int r = 0; r < 2; r++) begin
      lane_q[0].push_back({1'b0, 8'h10});
      lane_q[0].push_back({1'b1, 8'h11});
      lane_q[1].push_back({1'b0, 8'h20});
      lane_q[1].push_back({1'b1, 8'h21});
    end
    drive();
    for (int c = 0; c < 13; c++) begin
      #1;
      check($sformatf("t2_grant_c%0d", c), grant, gtab[c]);
      check($sformatf("t2_write_c%0d", c), fifo_write, wtab[c]);
      cycle();
    end
    check("t2_n", got.size(), 8);
    if (got.size() == 8)
      for (int i = 0; i < 8; i++) check($sformatf("t2_b%0d", i), got[i], t2_exp[i]);

    // FIFO full stall mid-message on req1 (longer than TIMEOUT)
    got.delete();
    to_base = n_to;
    lane_q[1].push_back({1'b0, 8'h30});
    lane_q[1].push_back({1'b0, 8'h31});
    lane_q[1].push_back({1'b1, 8'h32});
    drive(); #1;
    check("t3_idle_grant", grant, 0);
    cycle(); #1;
    check("t3_grant", grant, 4'b0010);
    check("t3_d0", fifo_data, 8'h30);
    cycle();
    fifo_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("t3_ready_k%0d", k), req_ready, 0);
      check($sformatf("t3_write_k%0d", k), fifo_write, 0);
      check($sformatf("t3_grant_k%0d", k), grant, 4'b0010);
      check($sformatf("t3_to_k%0d", k), timeout_err, 0);
      cycle();
    end
    fifo_full = 1'b0;
    #1;
    check("t3_resume_w", fifo_write, 1);
    check("t3_resume_d", fifo_data, 8'h31);
    cycle(); #1;
    check("t3_last_d", fifo_data, 8'h32);
    cycle(); #1;
    check("t3_end_grant", grant, 0);
    check("t3_n", got.size(), 3);
    if (got.size() == 3) check("t3_seq", {got[0], got[1], got[2]}, 24'h303132);
    check("t3_no_to", n_to - to_base, 0);

    // Idle timeout: req0 stalls after one byte while req1 waits
    got.delete();
    to_base = n_to;
    lane_q[0].push_back({1'b0, 8'h50});
    lane_q[1].push_back({1'b1, 8'h60});
    drive(); #1;
    check("t4_idle_grant", grant, 0);
    cycle(); #1;
    check("t4_grant0", grant, 4'b0001);
    check("t4_d0", fifo_data, 8'h50);
    for (int k = 0; k < 8; k++) begin
      cycle(); #1;
      check($sformatf("t4_hold_k%0d", k), grant, 4'b0001);
      check($sformatf("t4_to_k%0d", k), timeout_err, 0);
    end
    cycle(); #1;
    check("t4_to_pulse", timeout_err, 1);
    check("t4_to_grant", grant, 0);
    check("t4_to_busy", busy, 0);
    cycle(); #1;
    check("t4_grant1", grant, 4'b0010);
    check("t4_d1", fifo_data, 8'h60);
    check("t4_w1", fifo_write, 1);
    check("t4_to_low", timeout_err, 0);
    cycle(); #1;
    check("t4_end_grant", grant, 0);
    check("t4_to_count", n_to - to_base, 1);
    check_got("t4", 8'h50, 8'h60);

    // Reset during the second byte of a 4-byte req1 message
    got.delete();
    lane_q[1].push_back({1'b0, 8'h70});
    lane_q[1].push_back({1'b0, 8'h71});
    lane_q[1].push_back({1'b0, 8'h72});
    lane_q[1].push_back({1'b1, 8'h73});
    drive(); #1;
    cycle(); #1;
    check("t5_grant", grant, 4'b0010);
    check("t5_d0", fifo_data, 8'h70);
    cycle();
    reset = 1'b1;
    #1;
    check("t5_d1", fifo_data, 8'h71);
    cycle();
    reset = 1'b0;
    clear_lanes();
    drive();
    #1;
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_write", fifo_write, 0);
    check("t5_rst_ready", req_ready, 0);
    check_got("t5", 8'h70, 8'h71);
    got.delete();
    cycle();
    lane_q[0].push_back({1'b1, 8'h80});
    lane_q[3].push_back({1'b1, 8'h90});
    drive(); #1;
    check("t5_idle", grant, 0);
    cycle(); #1;
    check("t5_first_req0", grant, 4'b0001);
    check("t5_d80", fifo_data, 8'h80);
    cycle(); #1;
    check("t5_gap", grant, 0);
    cycle(); #1;
    check("t5_then_req3", grant, 4'b1000);
    check("t5_d90", fifo_data, 8'h90);
    cycle(); #1;
    check("t5_end", grant, 0);

    // Four lanes: after lane1 finishes, lanes 1 and 3 valid -> lane 3 wins
    got.delete();
    lane_q[1].push_back({1'b1, 8'hA1});
    drive(); #1;
    cycle();
    lane_q[1].push_back({1'b1, 8'hA2});
    lane_q[3].push_back({1'b1, 8'hB3});
    drive(); #1;
    check("t6_grant1", grant, 4'b0010);
    check("t6_ready1", req_ready, 4'b0010);
    check("t6_dA1", fifo_data, 8'hA1);
    cycle(); #1;
    check("t6_gap", grant, 0);
    cycle(); #1;
    check("t6_grant3", grant, 4'b1000);
    check("t6_dB3", fifo_data, 8'hB3);
    cycle(); #1;
    check("t6_gap2", grant, 0);
    cycle(); #1;
    check("t6_grant1b", grant, 4'b0010);
    check("t6_dA2", fifo_data, 8'hA2);
    cycle(); #1;
    check("t6_end", grant, 0);
    check("t6_n", got.size(), 3);
    if (got.size() == 3) check("t6_seq", {got[0], got[1], got[2]}, 24'hA1B3A2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
